// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED sharing controller.
// Holds the owner FSM encoding, the LED width and a counter-width helper.
package led_ctrl_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    // Width for a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit synchronizer plus debouncer for one asynchronous RPi GPIO line.
// The output flips only after the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
module gpio_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic dout_o
);

    localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values;
    // reset is synchronous, so it is simply the highest-priority branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = db_q;

endmodule

// File: rtl/led_share_ctrl.sv
// Shares four LEDs between two round-robin requesters, showing debounced RPi inputs when idle.
// Optional feature: define LED_HEARTBEAT_EN to replace led_out[3] in IDLE with a heartbeat.
module led_share_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int HOLD_CYCLES      = 1024,
    parameter int HEARTBEAT_CYCLES = 12000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LED_W-1:0] rpi_in,
    input  logic             req_a,
    input  logic [LED_W-1:0] pat_a,
    input  logic             req_b,
    input  logic [LED_W-1:0] pat_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [LED_W-1:0] rpi_db,
    output logic [LED_W-1:0] led_out
);

    localparam int            HW        = cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    for (genvar i = 0; i < LED_W; i++) begin : g_db
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .din_i  (rpi_in[i]),
            .dout_o (rpi_db[i])
        );
    end

    state_e          state_q;
    logic [HW-1:0]   hold_q;
    logic            rr_b_q;     // 1 when B was the last requester served
    logic            gnt_a_q;
    logic            gnt_b_q;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] idle_led;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rr_b_q  <= 1'b1;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_a && (!req_b || rr_b_q)) begin
                        state_q <= OWN_A;
                        gnt_a_q <= 1'b1;
                        gnt_b_q <= 1'b0;
                        hold_q  <= HOLD_LOAD;
                        rr_b_q  <= 1'b0;
                    end else if (req_b) begin
                        state_q <= OWN_B;
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b1;
                        hold_q  <= HOLD_LOAD;
                        rr_b_q  <= 1'b1;
                    end
                end
                OWN_A: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else if (req_b) begin
                        state_q <= OWN_B;
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b1;
                        hold_q  <= HOLD_LOAD;
                        rr_b_q  <= 1'b1;
                    end else if (!req_a) begin
                        state_q <= IDLE;
                        gnt_a_q <= 1'b0;
                    end
                end
                OWN_B: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - 1'b1;
                    end else if (req_a) begin
                        state_q <= OWN_A;
                        gnt_a_q <= 1'b1;
                        gnt_b_q <= 1'b0;
                        hold_q  <= HOLD_LOAD;
                        rr_b_q  <= 1'b0;
                    end else if (!req_b) begin
                        state_q <= IDLE;
                        gnt_b_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

`ifdef LED_HEARTBEAT_EN
    localparam int            BW     = cnt_w(HEARTBEAT_CYCLES);
    localparam logic [BW-1:0] HB_LAST = BW'(HEARTBEAT_CYCLES - 1);

    logic [BW-1:0] hb_cnt_q;
    logic          hb_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (hb_cnt_q == HB_LAST) begin
            hb_cnt_q <= '0;
            hb_q     <= ~hb_q;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    always_comb idle_led = {hb_q, rpi_db[LED_W-2:0]};
`else
    always_comb idle_led = rpi_db;
`endif

    // The LED register follows the pre-edge owner, so output trails the grant by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_q <= '0;
        end else begin
            case (state_q)
                OWN_A:   led_q <= pat_a;
                OWN_B:   led_q <= pat_b;
                default: led_q <= idle_led;
            endcase
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign led_out = led_q;

    a_grant_onehot : assert property (@(posedge clk) !(gnt_a_q && gnt_b_q));

endmodule

// File: tb/tb_led_share_ctrl.sv
// Self-checking bench for led_share_ctrl: directed corner cases, a vector table,
// and randomized traffic compared every cycle against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_led_share_ctrl;

    localparam int DB   = 16;
    localparam int HOLD = 8;
    localparam int HB   = 4;
`ifdef LED_HEARTBEAT_EN
    localparam logic [3:0] MASK = 4'h7;
`else
    localparam logic [3:0] MASK = 4'hF;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] rpi_in  = 4'h0;
    logic       req_a   = 1'b0;
    logic       req_b   = 1'b0;
    logic [3:0] pat_a   = 4'h0;
    logic [3:0] pat_b   = 4'h0;
    logic       gnt_a;
    logic       gnt_b;
    logic [3:0] rpi_db;
    logic [3:0] led_out;

    led_share_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rpi_in (rpi_in),
        .req_a  (req_a),
        .pat_a  (pat_a),
        .req_b  (req_b),
        .pat_b  (pat_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .rpi_db (rpi_db),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Owner: 0 none, 1 A, 2 B. Debounce: input seen two edges late must disagree DB times in a row.
    logic [3:0] m_hist [3] = '{4'h0, 4'h0, 4'h0};
    logic [3:0] m_db       = 4'h0;
    logic [3:0] m_led      = 4'h0;
    int         m_run [4]  = '{0, 0, 0, 0};
    int         m_owner    = 0;
    int         m_left     = 0;
    bit         m_last_b   = 1'b1;
    int         m_edges    = 0;
    bit         model_on   = 1'b0;
    int         m_other;
    bit         m_other_req;
    bit         m_own_req;

    task automatic m_grant(input int who);
        m_owner  = who;
        m_left   = HOLD - 1;
        m_last_b = (who == 2);
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            m_hist   = '{4'h0, 4'h0, 4'h0};
            m_db     = 4'h0;
            m_led    = 4'h0;
            m_run    = '{0, 0, 0, 0};
            m_owner  = 0;
            m_left   = 0;
            m_last_b = 1'b1;
            m_edges  = 0;
        end else begin
            if (m_owner == 1)      m_led = pat_a;
            else if (m_owner == 2) m_led = pat_b;
            else begin
                m_led = m_db;
`ifdef LED_HEARTBEAT_EN
                m_led[3] = ((m_edges / HB) % 2) == 1;
`endif
            end
            m_edges++;

            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = rpi_in;
            for (int i = 0; i < 4; i++) begin
                if (m_hist[2][i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i]  = m_hist[2][i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end

            if (m_owner == 0) begin
                if (req_a && req_b) m_grant(m_last_b ? 1 : 2);
                else if (req_a)     m_grant(1);
                else if (req_b)     m_grant(2);
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                m_other     = 3 - m_owner;
                m_other_req = (m_other == 1) ? req_a : req_b;
                m_own_req   = (m_owner == 1) ? req_a : req_b;
                if (m_other_req)     m_grant(m_other);
                else if (!m_own_req) m_owner = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on)
            check("model", {gnt_a, gnt_b, rpi_db, led_out},
                  {(m_owner == 1), (m_owner == 2), m_db, m_led});
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       ra;
        logic       rb;
        logic [3:0] pa;
        logic [3:0] pb;
        int         n;
        logic       ga;
        logic       gb;
        logic [3:0] led;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int k;
        int cnt;

        tbl[0]  = '{1'b1, 1'b1, 4'h5, 4'hA, 1, 1'b1, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 1'b1, 4'h5, 4'hA, 1, 1'b1, 1'b0, 4'h5};
        tbl[2]  = '{1'b1, 1'b1, 4'h5, 4'hA, 6, 1'b1, 1'b0, 4'h5};
        tbl[3]  = '{1'b1, 1'b1, 4'h5, 4'hA, 1, 1'b0, 1'b1, 4'h5};
        tbl[4]  = '{1'b1, 1'b1, 4'h5, 4'hA, 1, 1'b0, 1'b1, 4'hA};
        tbl[5]  = '{1'b1, 1'b1, 4'h5, 4'hA, 7, 1'b1, 1'b0, 4'hA};
        tbl[6]  = '{1'b0, 1'b0, 4'h5, 4'hA, 1, 1'b1, 1'b0, 4'h5};
        tbl[7]  = '{1'b0, 1'b0, 4'h5, 4'hA, 7, 1'b0, 1'b0, 4'h5};
        tbl[8]  = '{1'b0, 1'b0, 4'h5, 4'hA, 1, 1'b0, 1'b0, 4'h0};
        tbl[9]  = '{1'b0, 1'b1, 4'h5, 4'h3, 1, 1'b0, 1'b1, 4'h0};
        tbl[10] = '{1'b1, 1'b1, 4'h5, 4'h3, 1, 1'b0, 1'b1, 4'h3};

        // Reset with all RPi lines high, then measure release-to-LED latency.
        rpi_in  = 4'hF;
        reset_n = 1'b0;
        tick(1);
        model_on = 1'b1;
        tick(2);
        check("rst_led", led_out, 4'h0);
        check("rst_gnt", {gnt_a, gnt_b}, 2'b00);
        check("rst_db", rpi_db, 4'h0);
        reset_n = 1'b1;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if ((led_out & MASK) == (4'hF & MASK)) begin
                k = c;
                break;
            end
        end
        check("rst_to_led_cycles", k, 2 + DB + 1);

        // Bounce on bit 0: clear it first, toggle every 5 cycles, then hold high.
        rpi_in = 4'hE;
        tick(20);
        check("bounce_pre", rpi_db[0], 1'b0);
        for (int h = 0; h < 12; h++) begin
            rpi_in[0] = (h % 2 == 0);
            for (int c = 0; c < 5; c++) begin
                tick(1);
                check("bounce_hold", rpi_db[0], 1'b0);
            end
        end
        rpi_in[0] = 1'b1;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (rpi_db[0]) begin
                k = c;
                break;
            end
        end
        check("bounce_rise_cycles", k, 2 + DB);

        // Arbitration table from a fresh reset with quiet RPi lines.
        rpi_in  = 4'h0;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        foreach (tbl[i]) begin
            req_a = tbl[i].ra;
            req_b = tbl[i].rb;
            pat_a = tbl[i].pa;
            pat_b = tbl[i].pb;
            tick(tbl[i].n);
            check($sformatf("tbl%0d_gnt", i), {gnt_a, gnt_b}, {tbl[i].ga, tbl[i].gb});
            check($sformatf("tbl%0d_led", i), led_out & MASK, tbl[i].led & MASK);
        end

        // Early drop: a one-cycle request still owns the LEDs for exactly HOLD cycles.
        req_a = 1'b0;
        req_b = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (!gnt_a && !gnt_b) begin
                k = 1;
                break;
            end
        end
        check("drain_to_idle", k, 1);
        tick(2);
        pat_a = 4'h5;
        req_a = 1'b1;
        tick(1);
        req_a = 1'b0;
        cnt = gnt_a ? 1 : 0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (gnt_a) cnt++;
            else break;
        end
        check("early_drop_hold", cnt, HOLD);
        tick(1);
        check("early_drop_led", led_out & MASK, 4'h0);

        // Reset in the middle of a B grant (hold count 3).
        req_b = 1'b1;
        pat_b = 4'hC;
        tick(1);
        check("midrst_b_gnt", gnt_b, 1'b1);
        req_b = 1'b0;
        tick(HOLD - 1 - 3);
        check("midrst_b_still", gnt_b, 1'b1);
        reset_n = 1'b0;
        tick(1);
        check("midrst_b_gnt_off", {gnt_a, gnt_b}, 2'b00);
        check("midrst_b_led", led_out, 4'h0);
        reset_n = 1'b1;
        req_a   = 1'b1;
        req_b   = 1'b1;
        tick(1);
        check("midrst_b_then_a", {gnt_a, gnt_b}, 2'b10);

        // Reset during an A grant must also restore A-first priority.
        tick(3);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        check("midrst_a_then_a", {gnt_a, gnt_b}, 2'b10);
        req_a = 1'b0;
        req_b = 1'b0;
        tick(2 * HOLD + 4);

`ifdef LED_HEARTBEAT_EN
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            check("hb_idle", led_out[3], ((c - 1) / HB) % 2 == 1);
        end
        pat_a = 4'h0;
        req_a = 1'b1;
        tick(2);
        for (int c = 0; c < HOLD - 1; c++) begin
            check("hb_granted", {gnt_a, led_out[3]}, 2'b10);
            tick(1);
        end
        req_a = 1'b0;
        tick(2 * HOLD);
`endif

        // Randomized traffic; the model compares every cycle.
        for (int c = 0; c < 1500; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) req_a = ~req_a;
            if ($urandom_range(0, 19) == 0) req_b = ~req_b;
            pat_a = 4'($urandom);
            pat_b = 4'($urandom);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 29) == 0) rpi_in[i] = ~rpi_in[i];
            tick(1);
        end

        model_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_share_ctrl.md
LED_SHARE_CTRL -- requirements
Module: led_share_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a synchronized rpi_in bit is accepted.
REQ-002 Parameter HOLD_CYCLES, default 1024: minimum number of cycles a granted requester owns the LEDs.
REQ-003 Parameter HEARTBEAT_CYCLES, default 12000000: heartbeat half-period in cycles.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 rpi_in  input  4  asynchronous RPi GPIO lines.
REQ-007 req_a  input  1  requester A wants the LEDs; level-held until granted and done.
REQ-008 pat_a  input  4  LED pattern from A; sampled every cycle while A is granted.
REQ-009 req_b  input  1  requester B request; same rules as req_a.
REQ-010 pat_b  input  4  LED pattern from B.
REQ-011 gnt_a  output  1  A currently owns the LEDs.
REQ-012 gnt_b  output  1  B currently owns the LEDs.
REQ-013 rpi_db  output  4  debounced RPi inputs.
REQ-014 led_out  output  4  registered LED drive.

Function
REQ-015 Each rpi_in bit shall pass through a 2-flop synchronizer, then a per-bit debouncer: rpi_db[i] updates only after the synchronized value differs from rpi_db[i] for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts that bit's count.
REQ-016 FSM states: IDLE, OWN_A, OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B; the two grants are never both 1.
REQ-017 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the requester not served last (rr pointer; after reset, A wins).
REQ-018 On grant entry, the hold counter loads HOLD_CYCLES-1 and decrements each cycle to 0; the grant shall not change before the counter reaches 0, even if the owner drops its request.
REQ-019 Hold expired in OWN_x: other requester asserted -> switch directly to the other's OWN state (counter reloads); else owner request still high -> remain, counter stays 0; else -> IDLE.
REQ-020 The rr pointer shall update to the served requester on every grant entry.
REQ-021 led_out is registered, one cycle behind state: IDLE -> rpi_db, OWN_A -> pat_a, OWN_B -> pat_b.
REQ-022 Arbitration latency: a request seen in IDLE at cycle n shall assert gnt at n+1 and put the pattern on led_out at n+2.
REQ-023 rpi_in to led_out latency in IDLE: 2 sync + DEBOUNCE_CYCLES + 1 output register cycles.

Reset
REQ-024 While reset_n=0 at a clock edge: state IDLE, gnt_a=gnt_b=0, led_out=0, rpi_db=0, synchronizers=0, all counters=0, rr pointer=B-last (A next).
REQ-025 Reset asserted mid-grant shall abort the grant on that edge; no partial hold is remembered.

Configuration
REQ-026 Macro LED_HEARTBEAT_EN: when defined, in IDLE led_out[3] shall show a heartbeat that toggles every HEARTBEAT_CYCLES cycles (reset value 0), and led_out[2:0]=rpi_db[2:0]; in OWN states, patterns pass unmodified.
REQ-027 Without LED_HEARTBEAT_EN, no heartbeat counter shall exist and IDLE shows all four rpi_db bits.

Structure
REQ-028 Package led_ctrl_pkg shall hold the FSM state typedef (IDLE/OWN_A/OWN_B) and the LED width constant (4).
REQ-029 Sub-module gpio_debounce (single bit, DEBOUNCE_CYCLES parameter, includes the synchronizer) shall be instantiated once per rpi_in bit.
REQ-030 Counter widths shall be derived with $clog2 of the corresponding parameter.

Verification
REQ-031 Reset: hold reset_n=0 for 3 cycles with rpi_in=4'hF -> led_out=0, gnt_a=gnt_b=0; release -> led_out=4'hF after 2+16+1 cycles.
REQ-032 Bounce: toggle rpi_in[0] every 5 cycles for 60 cycles, then hold at 1 -> rpi_db[0] stays 0 during toggling and rises 2+16 cycles after the final edge.
REQ-033 Contention: req_a=req_b=1 from reset, pat_a=4'h5, pat_b=4'hA, HOLD_CYCLES=8 -> gnt_a for 8 cycles, then gnt_b for 8, alternating; led_out follows 5/A with 1-cycle lag.
REQ-034 Early drop: req_a pulses 1 cycle -> gnt_a held exactly HOLD_CYCLES cycles, then IDLE, led_out returns to rpi_db.
REQ-035 Reset mid-grant: assert reset_n=0 at hold count 3 of OWN_B -> next cycle gnt_b=0, led_out=0; after release with req_a=req_b=1, A granted first.
REQ-036 With LED_HEARTBEAT_EN, HEARTBEAT_CYCLES=4, idle -> led_out[3] toggles every 4 cycles; with req_a=1, pat_a=4'h0 -> led_out[3]=0 while granted.
